// File: rtl/regfile_sb.sv
// Multi-read-port register file with write-through bypass and a per-register
// busy scoreboard tracking in-flight destination writes.
module regfile_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NREAD      = 2,
  parameter int BYPASS     = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wen,
  input  logic [ADDR_WIDTH-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic                          alloc_en,
  input  logic [ADDR_WIDTH-1:0]         alloc_addr,
  input  logic [NREAD*ADDR_WIDTH-1:0]   raddr,
  output logic [NREAD*DATA_WIDTH-1:0]   rdata,
  output logic [NREAD-1:0]              rbusy,
  input  logic [ADDR_WIDTH-1:0]         dbg_addr,
  output logic [DATA_WIDTH-1:0]         dbg_data,
  output logic [2**ADDR_WIDTH-1:0]      busy_vec,
  output logic [ADDR_WIDTH:0]           busy_cnt
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam bit BYP   = (BYPASS != 0);

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_next;
  logic [ADDR_WIDTH:0]   cnt;
  logic                  alloc_eff;
  logic                  cnt_inc;
  logic                  cnt_dec;
  logic [ADDR_WIDTH-1:0] ra [NREAD];

  assign alloc_eff = alloc_en && (alloc_addr != '0);

  // Allocation is applied after the clear so a same-register alloc+write keeps busy set.
  always_comb begin
    busy_next = busy;
    if (wen) busy_next[waddr] = 1'b0;
    if (alloc_en) busy_next[alloc_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Count tracks only real 0->1 and 1->0 transitions, so it cannot wrap.
  assign cnt_inc = alloc_eff && !busy[alloc_addr];
  assign cnt_dec = wen && (waddr != '0) && busy[waddr] &&
                   !(alloc_eff && (alloc_addr == waddr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) regs[k] <= '0;
      busy <= '0;
      cnt  <= '0;
    end else begin
      if (wen && (waddr != '0)) regs[waddr] <= wdata;
      busy <= busy_next;
      case ({cnt_inc, cnt_dec})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREAD; gi++) begin : g_ra
      assign ra[gi] = raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    end
  endgenerate

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (ra[i] != '0) begin
        if (BYP && wen && (waddr == ra[i])) begin
          rdata[i*DATA_WIDTH +: DATA_WIDTH] = wdata;
          rbusy[i] = alloc_en && (alloc_addr == ra[i]);
        end else begin
          rdata[i*DATA_WIDTH +: DATA_WIDTH] = regs[ra[i]];
          rbusy[i] = busy[ra[i]];
        end
      end
    end
  end

  assign dbg_data = regs[dbg_addr];
  assign busy_vec = busy;
  assign busy_cnt = cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: table vectors against bypass and non-bypass instances,
// plus hand sequences for reset, and full scoreboard fill/drain.
module tb_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        alloc_en;
  logic [4:0]  alloc_addr;
  logic [9:0]  raddr;
  logic [4:0]  dbg_addr;

  logic [63:0] rdata_a, rdata_b;
  logic [1:0]  rbusy_a, rbusy_b;
  logic [31:0] dbg_a, dbg_b;
  logic [31:0] bvec_a, bvec_b;
  logic [5:0]  cnt_a, cnt_b;

  regfile_sb #(.BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .raddr(raddr),
    .rdata(rdata_a), .rbusy(rbusy_a), .dbg_addr(dbg_addr), .dbg_data(dbg_a),
    .busy_vec(bvec_a), .busy_cnt(cnt_a)
  );

  regfile_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .raddr(raddr),
    .rdata(rdata_b), .rbusy(rbusy_b), .dbg_addr(dbg_addr), .dbg_data(dbg_b),
    .busy_vec(bvec_b), .busy_cnt(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        al;
    logic [4:0]  aaddr;
    logic [4:0]  ra0, ra1;
    logic [31:0] rd0, rd1, rd1_nb;
    logic [1:0]  rb, rb_nb;
    logic [5:0]  cnt;
    logic [31:0] bvec;
    logic [31:0] dbg;
  } vec_t;

  typedef struct {
    string       name;
    logic [63:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  vec_t vt[17];

  function automatic vec_t mk(logic w, logic [4:0] wa, logic [31:0] wd, logic a, logic [4:0] aa,
                              logic [4:0] r0, logic [4:0] r1, logic [31:0] e0, logic [31:0] e1,
                              logic [31:0] e1nb, logic [1:0] b, logic [1:0] bnb, logic [5:0] c,
                              logic [31:0] bv, logic [31:0] d);
    vec_t v;
    v.wen = w; v.waddr = wa; v.wdata = wd; v.al = a; v.aaddr = aa; v.ra0 = r0; v.ra1 = r1;
    v.rd0 = e0; v.rd1 = e1; v.rd1_nb = e1nb; v.rb = b; v.rb_nb = bnb; v.cnt = c;
    v.bvec = bv; v.dbg = d;
    return v;
  endfunction

  task automatic expect_val(string n, logic [63:0] e);
    exp_t x;
    x.name = n;
    x.exp  = e;
    sbq.push_back(x);
  endtask

  task automatic observe(logic [63:0] act);
    exp_t x;
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $display("FAIL sb_empty: got %h with no expectation queued", act);
    end else begin
      x = sbq.pop_front();
      if (act !== x.exp) begin
        bad++;
        $display("FAIL %s: got %h expected %h", x.name, act, x.exp);
      end
    end
  endtask

  task automatic drive(logic w, logic [4:0] wa, logic [31:0] wd, logic a, logic [4:0] aa,
                       logic [4:0] r0, logic [4:0] r1);
    wen = w; waddr = wa; wdata = wd; alloc_en = a; alloc_addr = aa;
    raddr = {r1, r0}; dbg_addr = r1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);

    vt[0]  = mk(1, 3, 32'hDEADBEEF, 0, 0, 3, 3, 32'hDEADBEEF, 32'hDEADBEEF, 0, 2'b00, 2'b00, 0, 0, 0);
    vt[1]  = mk(1, 0, 32'hFFFFFFFF, 0, 0, 3, 0, 32'hDEADBEEF, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    vt[2]  = mk(1, 7, 32'h11, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    vt[3]  = mk(1, 7, 32'hA5, 0, 0, 3, 7, 32'hDEADBEEF, 32'hA5, 32'h11, 2'b00, 2'b00, 0, 0, 32'h11);
    vt[4]  = mk(0, 0, 0, 0, 0, 3, 7, 32'hDEADBEEF, 32'hA5, 32'hA5, 2'b00, 2'b00, 0, 0, 32'hA5);
    vt[5]  = mk(0, 0, 0, 1, 4, 4, 9, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    vt[6]  = mk(0, 0, 0, 1, 9, 4, 9, 0, 0, 0, 2'b01, 2'b01, 1, 32'h10, 0);
    vt[7]  = mk(0, 0, 0, 1, 4, 4, 9, 0, 0, 0, 2'b11, 2'b11, 2, 32'h210, 0);
    vt[8]  = mk(1, 9, 32'h99, 0, 0, 4, 9, 0, 32'h99, 0, 2'b01, 2'b11, 2, 32'h210, 0);
    vt[9]  = mk(0, 0, 0, 0, 0, 4, 9, 0, 32'h99, 32'h99, 2'b01, 2'b01, 1, 32'h10, 32'h99);
    vt[10] = mk(0, 0, 0, 1, 6, 6, 6, 0, 0, 0, 2'b00, 2'b00, 1, 32'h10, 0);
    vt[11] = mk(1, 6, 32'h66, 1, 6, 6, 6, 32'h66, 32'h66, 0, 2'b11, 2'b11, 2, 32'h50, 0);
    vt[12] = mk(0, 0, 0, 0, 0, 6, 6, 32'h66, 32'h66, 32'h66, 2'b11, 2'b11, 2, 32'h50, 32'h66);
    vt[13] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2, 32'h50, 0);
    vt[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2, 32'h50, 0);
    vt[15] = mk(1, 3, 32'h33, 0, 0, 3, 3, 32'h33, 32'h33, 32'hDEADBEEF, 2'b00, 2'b00, 2, 32'h50, 32'hDEADBEEF);
    vt[16] = mk(0, 0, 0, 0, 0, 3, 4, 32'h33, 0, 0, 2'b10, 2'b10, 2, 32'h50, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    expect_val("init_cnt", 0);  observe(cnt_a);
    expect_val("init_bvec", 0); observe(bvec_a);

    for (int i = 0; i < 17; i++) begin
      next_cycle();
      drive(vt[i].wen, vt[i].waddr, vt[i].wdata, vt[i].al, vt[i].aaddr, vt[i].ra0, vt[i].ra1);
      expect_val($sformatf("v%0d_rd0", i), vt[i].rd0);
      expect_val($sformatf("v%0d_rd1", i), vt[i].rd1);
      expect_val($sformatf("v%0d_rd1_nb", i), vt[i].rd1_nb);
      expect_val($sformatf("v%0d_rbusy", i), vt[i].rb);
      expect_val($sformatf("v%0d_rbusy_nb", i), vt[i].rb_nb);
      expect_val($sformatf("v%0d_cnt", i), vt[i].cnt);
      expect_val($sformatf("v%0d_bvec", i), vt[i].bvec);
      expect_val($sformatf("v%0d_dbg", i), vt[i].dbg);
      #1;
      observe(rdata_a[31:0]);
      observe(rdata_a[63:32]);
      observe(rdata_b[63:32]);
      observe(rbusy_a);
      observe(rbusy_b);
      observe(cnt_a);
      observe(bvec_a);
      observe(dbg_a);
    end

    // Asynchronous reset in mid-cycle with reg5 holding data and marked busy.
    next_cycle();
    drive(1, 5, 32'h1234, 1, 5, 5, 5);
    next_cycle();
    drive(0, 0, 0, 0, 0, 5, 5);
    expect_val("pre_rst_rd0", 32'h1234); expect_val("pre_rst_rbusy", 2'b11);
    #1;
    observe(rdata_a[31:0]); observe(rbusy_a);
    #1;
    rst_n = 1'b0;
    #1;
    expect_val("rst_rd0", 0);    observe(rdata_a[31:0]);
    expect_val("rst_rd0_nb", 0); observe(rdata_b[31:0]);
    expect_val("rst_rbusy", 0);  observe(rbusy_a);
    expect_val("rst_bvec", 0);   observe(bvec_a);
    expect_val("rst_cnt", 0);    observe(cnt_a);
    expect_val("rst_dbg", 0);    observe(dbg_a);
    drive(1, 5, 32'hBAD, 1, 8, 5, 5);
    next_cycle();
    drive(0, 0, 0, 0, 0, 5, 5);
    rst_n = 1'b1;
    #1;
    expect_val("rst_discard_dbg", 0); observe(dbg_a);
    expect_val("rst_discard_cnt", 0); observe(cnt_a);
    next_cycle();
    expect_val("post_rst_bvec", 0); observe(bvec_a);

    // Fill every allocatable register, then drain with writebacks.
    for (int k = 1; k < 32; k++) begin
      next_cycle();
      drive(0, 0, 0, 1, 5'(k), 31, 0);
    end
    next_cycle();
    drive(0, 0, 0, 0, 0, 31, 0);
    #1;
    expect_val("full_cnt", 31);             observe(cnt_a);
    expect_val("full_bvec", 32'hFFFFFFFE); observe(bvec_a);
    expect_val("full_rbusy", 2'b01);       observe(rbusy_a);
    next_cycle();
    drive(0, 0, 0, 1, 1, 31, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 31, 0);
    #1;
    expect_val("full_realloc_cnt", 31); observe(cnt_a);
    for (int k = 1; k < 32; k++) begin
      next_cycle();
      drive(1, 5'(k), 32'(k), 0, 0, 31, 2);
    end
    next_cycle();
    drive(0, 0, 0, 0, 0, 31, 2);
    #1;
    expect_val("drain_cnt", 0);  observe(cnt_a);
    expect_val("drain_bvec", 0); observe(bvec_a);
    expect_val("drain_dbg", 2);  observe(dbg_a);
    next_cycle();
    drive(1, 2, 32'h77, 0, 0, 2, 2);
    next_cycle();
    drive(0, 0, 0, 0, 0, 2, 2);
    #1;
    expect_val("idle_write_cnt", 0);   observe(cnt_a);
    expect_val("idle_write_rd", 32'h77); observe(rdata_b[31:0]);

    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: got %0d entries expected 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read-port integer register file with write-through bypass and a per-register busy scoreboard. It is the next generation of the single-cycle CPU's register file and serves a pipelined core. The decode stage reads operands and checks hazards. The issue stage allocates destination registers. Writeback writes results and retires the busy marks. Registers and scoreboard clear on reset.

## Interface
- ADDR_WIDTH, 5, register index width; depth is 2**ADDR_WIDTH
- DATA_WIDTH, 32, register data width
- NREAD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle writeback data/busy-clear visible on read ports; 0 = visible next cycle
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wen  in  1  writeback enable
- waddr  in  ADDR_WIDTH  writeback index
- wdata  in  DATA_WIDTH  writeback data
- alloc_en  in  1  issue allocates a destination register (sets busy)
- alloc_addr  in  ADDR_WIDTH  allocated index
- raddr  in  NREAD*ADDR_WIDTH  read indices, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- rdata  out  NREAD*DATA_WIDTH  read data, packed like raddr
- rbusy  out  NREAD  operand i has a pending write
- dbg_addr  in  ADDR_WIDTH  debug read index
- dbg_data  out  DATA_WIDTH  debug read data, always registered state, never bypassed
- busy_vec  out  2**ADDR_WIDTH  scoreboard bits, bit k = register k
- busy_cnt  out  ADDR_WIDTH+1  number of set busy bits

## Operation
- Reset (rst_n low, asynchronous): all registers = 0, busy_vec = 0, busy_cnt = 0. Consequently rdata = 0, rbusy = 0 and dbg_data = 0 while reset is held. Reset asserted mid-operation discards any write or allocation in that cycle.
- Register 0 is hardwired:
  - writes to index 0 are ignored;
  - alloc to index 0 is ignored;
  - reads of index 0 return 0 with rbusy = 0.
- Write: on rising edge with wen=1 and waddr≠0, reg[waddr] <= wdata.
- Scoreboard: next busy[k] = (alloc_en && alloc_addr==k && k≠0) | (busy[k] && !(wen && waddr==k)).
  - If alloc and write target the same register in one cycle, set wins. The busy bit stays 1 and represents the new owner; the data is still written.
  - wen to a register that is not busy is legal. It writes the data and leaves busy at 0.
- busy_cnt equals popcount(busy_vec) at all times. It is registered and updated each edge by +1, -1 or 0. It never wraps; the maximum is 2**ADDR_WIDTH-1.
- Read port i, combinational from raddr:
  - BYPASS=1, wen=1, waddr==raddr_i, raddr_i≠0: rdata_i = wdata. rbusy_i = 0, unless alloc_en && alloc_addr==raddr_i, in which case rbusy_i = 1.
  - Otherwise: rdata_i = reg[raddr_i], rbusy_i = busy[raddr_i].
  - BYPASS=0: always the registered value and registered busy bit.
- All read ports are independent. Identical addresses on several ports return identical results.

## Timing
- Read latency: 0 cycles (combinational). Write and scoreboard latency: 1 edge.
- Writeback to consumer:
  - BYPASS=1: data is usable in the same cycle.
  - BYPASS=0: data is usable from the cycle after the edge.
- Alloc to busy: rbusy rises the cycle after alloc_en. A read in the alloc cycle still sees the old busy state. An exception is the same-cycle bypass case under BYPASS=1, where rbusy_i = 1 as given above.
- Reset deassertion: the first state change is at the first rising edge after rst_n goes high.
- No handshake or backpressure: the producer guarantees wen/alloc validity each cycle.

## Test plan
- Reset: preload reg5=0x1234 with busy[5]=1. Assert rst_n=0 asynchronously mid-cycle. Required, immediately: rdata for raddr=5 is 0, busy_vec=0, busy_cnt=0.
- Write/read: wen, waddr=3, wdata=0xDEADBEEF. Required:
  - next cycle, every read port at raddr=3 returns 0xDEADBEEF;
  - a write of 0xFFFFFFFF to index 0 leaves raddr=0 reading 0.
- Bypass: BYPASS=1. In one cycle wen, waddr=7, wdata=0xA5, with port 1 raddr=7 and reg7=0x11. Required: rdata1=0xA5 in that cycle. Repeat with BYPASS=0: required rdata1=0x11 in that cycle and 0xA5 next cycle.
- Scoreboard: alloc 4, 9, 4 on successive cycles, then wen waddr=9. Required sequence:
  - busy_cnt: 1, 2, 2, then 1;
  - rbusy for raddr=9 drops to 0 after the write edge (same cycle if BYPASS=1);
  - busy_vec bit 4 stays 1.
- Collision: alloc_en and wen both on index 6 with busy[6]=1. Required: busy[6] stays 1, busy_cnt unchanged, reg6 updated. Also alloc_en at index 0: required busy_cnt unchanged, rbusy for raddr=0 is 0.
- Full scoreboard: allocate indices 1..2**ADDR_WIDTH-1. Required: busy_cnt=31 (ADDR_WIDTH=5). Then release all via writes: required busy_cnt=0 with no wrap.
